// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/MRET sequencing and interrupt pending logic.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their user shadows.
module csr_trap_unit #(
    parameter int unsigned NUM_IRQ   = 4,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [11:0]        i_csrAddr,
    input  logic [1:0]         i_csrOp,
    input  logic [31:0]        i_wd,
    output logic [31:0]        o_rd,
    output logic               o_illegal,
    input  logic               i_trapValid,
    input  logic [31:0]        i_trapPc,
    input  logic [31:0]        i_trapCause,
    input  logic [31:0]        i_trapVal,
    input  logic               i_mretValid,
    input  logic               i_retire,
    input  logic               i_timerIrq,
    input  logic [NUM_IRQ-1:0] i_irqLines,
    output logic               o_irqPending,
    output logic [31:0]        o_trapTarget,
    output logic [31:0]        o_mepcOut
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSTATUSH = 12'h310;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK = 32'h0000_0880 |
                                       (((32'h1 << NUM_IRQ) - 32'h1) << 16);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
`ifdef CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
`endif

    logic [31:0] w_mip;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_impl;
    logic        w_active;
    logic        w_wants_write;
    logic        w_illegal;
    logic        w_wr;
    logic [31:0] w_base;
    logic        w_unused;

    always_comb begin
        w_mip              = 32'h0;
        w_mip[7]           = i_timerIrq;
        w_mip[11]          = |i_irqLines;
        w_mip[16+:NUM_IRQ] = i_irqLines;
    end

    always_comb begin
        w_impl = 1'b1;
        w_old  = 32'h0;
        case (i_csrAddr)
            ADDR_MSTATUS:  w_old = {19'h0, 2'b11, 3'b000, r_mstatus_mpie, 3'b000,
                                    r_mstatus_mie, 3'b000};
            ADDR_MSTATUSH: w_old = 32'h0;
            ADDR_MISA:     w_old = MISA_VAL;
            ADDR_MIE:      w_old = r_mie;
            ADDR_MIP:      w_old = w_mip;
            ADDR_MTVEC:    w_old = r_mtvec;
            ADDR_MSCRATCH: w_old = r_mscratch;
            ADDR_MEPC:     w_old = r_mepc;
            ADDR_MCAUSE:   w_old = r_mcause;
            ADDR_MTVAL:    w_old = r_mtval;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE,    ADDR_CYCLE:    w_old = r_mcycle[31:0];
            ADDR_MCYCLEH,   ADDR_CYCLEH:   w_old = r_mcycle[63:32];
            ADDR_MINSTRET,  ADDR_INSTRET:  w_old = r_minstret[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: w_old = r_minstret[63:32];
`endif
            default:       w_impl = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read: it neither traps on read-only
    // space nor overrides a counter increment.
    assign w_active      = (i_csrOp != OP_NONE);
    assign w_wants_write = (i_csrOp == OP_RW) || (i_csrOp[1] && (i_wd != 32'h0));
    assign w_illegal     = w_active &&
                           (!w_impl || ((i_csrAddr[11:10] == 2'b11) && w_wants_write));
    assign w_wr          = w_active && w_wants_write && !w_illegal;

    always_comb begin
        case (i_csrOp)
            OP_RW:   w_new = i_wd;
            OP_RS:   w_new = w_old | i_wd;
            OP_RC:   w_new = w_old & ~i_wd;
            default: w_new = w_old;
        endcase
    end

    assign o_rd         = w_active ? w_old : 32'h0;
    assign o_illegal    = w_illegal;
    assign o_irqPending = r_mstatus_mie & (|(w_mip & r_mie));
    assign o_mepcOut    = r_mepc;

    assign w_base = {r_mtvec[31:2], 2'b00};
    always_comb begin
        if ((r_mtvec[1:0] == 2'b01) && i_trapCause[31]) begin
            o_trapTarget = w_base + {i_trapCause[29:0], 2'b00};
        end else begin
            o_trapTarget = w_base;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'h0;
            r_mtvec        <= MTVEC_RST;
            r_mscratch     <= 32'h0;
            r_mepc         <= 32'h0;
            r_mcause       <= 32'h0;
            r_mtval        <= 32'h0;
        end else begin
            // Trap beats MRET beats CSR write on the fields they share.
            if (i_trapValid) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mepc         <= i_trapPc & ~32'h3;
                r_mcause       <= i_trapCause;
                r_mtval        <= i_trapVal;
            end else begin
                if (i_mretValid) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end else if (w_wr && (i_csrAddr == ADDR_MSTATUS)) begin
                    r_mstatus_mie  <= w_new[3];
                    r_mstatus_mpie <= w_new[7];
                end
                if (w_wr && (i_csrAddr == ADDR_MEPC)) begin
                    r_mepc <= {w_new[31:2], 2'b00};
                end
                if (w_wr && (i_csrAddr == ADDR_MCAUSE)) begin
                    r_mcause <= w_new;
                end
                if (w_wr && (i_csrAddr == ADDR_MTVAL)) begin
                    r_mtval <= w_new;
                end
            end
            if (w_wr && (i_csrAddr == ADDR_MIE)) begin
                r_mie <= w_new & MIE_MASK;
            end
            if (w_wr && (i_csrAddr == ADDR_MTVEC)) begin
                // Reserved modes 1x keep the previous mode; base always updates.
                r_mtvec <= {w_new[31:2], (w_new[1] ? r_mtvec[1:0] : w_new[1:0])};
            end
            if (w_wr && (i_csrAddr == ADDR_MSCRATCH)) begin
                r_mscratch <= w_new;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            if (w_wr && (i_csrAddr == ADDR_MCYCLE)) begin
                r_mcycle <= {r_mcycle[63:32], w_new};
            end else if (w_wr && (i_csrAddr == ADDR_MCYCLEH)) begin
                r_mcycle <= {w_new, r_mcycle[31:0]};
            end else begin
                r_mcycle <= r_mcycle + 64'h1;
            end
            if (w_wr && (i_csrAddr == ADDR_MINSTRET)) begin
                r_minstret <= {r_minstret[63:32], w_new};
            end else if (w_wr && (i_csrAddr == ADDR_MINSTRETH)) begin
                r_minstret <= {w_new, r_minstret[31:0]};
            end else if (i_retire) begin
                r_minstret <= r_minstret + 64'h1;
            end
        end
    end

    assign w_unused = i_trapCause[30];
`else
    assign w_unused = i_trapCause[30] ^ i_retire;
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: table of CSR accesses plus trap/MRET/IRQ sequences.
// Covers the counter build as well when CSR_COUNTERS_EN is defined.
module tb_csr_trap_unit;

    localparam int unsigned NIRQ = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [11:0]     addr;
    logic [1:0]      op;
    logic [31:0]     wd;
    logic [31:0]     rd;
    logic            ill;
    logic            trap_valid;
    logic [31:0]     trap_pc;
    logic [31:0]     trap_cause;
    logic [31:0]     trap_val;
    logic            mret;
    logic            retire;
    logic            timer;
    logic [NIRQ-1:0] irq;
    logic            irq_pend;
    logic [31:0]     tgt;
    logic [31:0]     mepc_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    csr_trap_unit #(
        .NUM_IRQ   (NIRQ),
        .MTVEC_RST (32'h0000_0000)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_csrAddr    (addr),
        .i_csrOp      (op),
        .i_wd         (wd),
        .o_rd         (rd),
        .o_illegal    (ill),
        .i_trapValid  (trap_valid),
        .i_trapPc     (trap_pc),
        .i_trapCause  (trap_cause),
        .i_trapVal    (trap_val),
        .i_mretValid  (mret),
        .i_retire     (retire),
        .i_timerIrq   (timer),
        .i_irqLines   (irq),
        .o_irqPending (irq_pend),
        .o_trapTarget (tgt),
        .o_mepcOut    (mepc_out)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CSR access: drive, queue the expectation, compare mid-cycle, commit on the edge.
    task automatic csr(input string name, input logic [1:0] o, input logic [11:0] a,
                       input logic [31:0] w, input logic [31:0] exp_rd, input logic exp_ill);
        exp_t e;
        op   = o;
        addr = a;
        wd   = w;
        sb_q.push_back('{name, exp_rd, exp_ill});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk32({name, " scoreboard"}, 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            chk32({e.name, " rd"}, rd, e.rd);
            chk32({e.name, " illegal"}, {31'h0, ill}, {31'h0, e.ill});
        end
        step();
        op = 2'b00;
        wd = 32'h0;
    endtask

    task automatic wr_nochk(input logic [11:0] a, input logic [31:0] w);
        op   = 2'b01;
        addr = a;
        wd   = w;
        step();
        op = 2'b00;
        wd = 32'h0;
    endtask

    initial begin
        rst_n      = 1'b0;
        op         = 2'b00;
        addr       = 12'h0;
        wd         = 32'h0;
        trap_valid = 1'b0;
        trap_pc    = 32'h0;
        trap_cause = 32'h0;
        trap_val   = 32'h0;
        mret       = 1'b0;
        retire     = 1'b0;
        timer      = 1'b0;
        irq        = '0;

        vecs.push_back('{"misa rw",        2'b01, 12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0});
        vecs.push_back('{"mstatus rd",     2'b10, 12'h300, 32'h0000_0000, 32'h0000_1800, 1'b0});
        vecs.push_back('{"mtvec rw",       2'b01, 12'h305, 32'h8000_0101, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mtvec rd",       2'b10, 12'h305, 32'h0000_0000, 32'h8000_0101, 1'b0});
        vecs.push_back('{"mtvec mode2 wr", 2'b01, 12'h305, 32'h0000_0202, 32'h8000_0101, 1'b0});
        vecs.push_back('{"mtvec kept",     2'b10, 12'h305, 32'h0000_0000, 32'h0000_0201, 1'b0});
        vecs.push_back('{"mtvec rc",       2'b11, 12'h305, 32'h0000_0001, 32'h0000_0201, 1'b0});
        vecs.push_back('{"mtvec mode0",    2'b10, 12'h305, 32'h0000_0000, 32'h0000_0200, 1'b0});
        vecs.push_back('{"mepc rw",        2'b01, 12'h341, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mepc align",     2'b10, 12'h341, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0});
        vecs.push_back('{"mscratch rw",    2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mscratch rc",    2'b11, 12'h340, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"mscratch rd",    2'b10, 12'h340, 32'h0000_0000, 32'hDEAD_0000, 1'b0});
        vecs.push_back('{"mie rw",         2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mie mask",       2'b10, 12'h304, 32'h0000_0000, 32'h000F_0880, 1'b0});
        vecs.push_back('{"mstatus rw",     2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0});
        vecs.push_back('{"mstatus mask",   2'b10, 12'h300, 32'h0000_0000, 32'h0000_1888, 1'b0});
        vecs.push_back('{"mstatus rc",     2'b11, 12'h300, 32'h0000_0008, 32'h0000_1888, 1'b0});
        vecs.push_back('{"mstatus rc rd",  2'b10, 12'h300, 32'h0000_0000, 32'h0000_1880, 1'b0});
        vecs.push_back('{"misa wr ign",    2'b01, 12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0});
        vecs.push_back('{"misa rd",        2'b10, 12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0});
        vecs.push_back('{"mstatush",       2'b01, 12'h310, 32'h0000_0005, 32'h0000_0000, 1'b0});
        vecs.push_back('{"unimpl 123",     2'b01, 12'h123, 32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{"unimpl F11",     2'b10, 12'hF11, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"op none",        2'b00, 12'h301, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mcause rw",      2'b01, 12'h342, 32'h1234_5678, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mtval rw",       2'b01, 12'h343, 32'h0000_0009, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mcause rd",      2'b10, 12'h342, 32'h0000_0000, 32'h1234_5678, 1'b0});
        vecs.push_back('{"mtval rd",       2'b10, 12'h343, 32'h0000_0000, 32'h0000_0009, 1'b0});
        vecs.push_back('{"mip wr ign",     2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mip rd",         2'b10, 12'h344, 32'h0000_0000, 32'h0000_0000, 1'b0});

        // Reset behaviour: first edge loads reset state, outputs stay combinational.
        step();
        timer = 1'b1;
        #1;
        chk32("reset irqPending", {31'h0, irq_pend}, 32'h0);
        chk32("reset mepcOut", mepc_out, 32'h0);
        trap_cause = 32'h8000_0003;
        #1;
        chk32("reset trapTarget", tgt, 32'h0);
        csr("reset misa", 2'b01, 12'h301, 32'h0, 32'h4000_0100, 1'b0);
        csr("reset mstatus", 2'b01, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        timer = 1'b0;
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            csr(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd,
                vecs[i].exp_ill);
        end

        // Vectored trap target.
        csr("mtvec vec", 2'b01, 12'h305, 32'h8000_0101, 32'h0000_0200, 1'b0);
        trap_cause = 32'h8000_0007;
        #1;
        chk32("trapTarget vectored", tgt, 32'h8000_011C);
        trap_cause = 32'h0000_0002;
        #1;
        chk32("trapTarget exception", tgt, 32'h8000_0100);

        // Trap entry and MRET.
        csr("set MIE", 2'b01, 12'h300, 32'h0000_0008, 32'h0000_1880, 1'b0);
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_1236;
        trap_cause = 32'h0000_0002;
        trap_val   = 32'h0000_ABCD;
        step();
        trap_valid = 1'b0;
        chk32("trap mepcOut", mepc_out, 32'h0000_1234);
        csr("trap mstatus", 2'b10, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
        csr("trap mcause", 2'b10, 12'h342, 32'h0, 32'h0000_0002, 1'b0);
        csr("trap mtval", 2'b10, 12'h343, 32'h0, 32'h0000_ABCD, 1'b0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        csr("mret mstatus", 2'b10, 12'h300, 32'h0, 32'h0000_1888, 1'b0);
        chk32("mret mepcOut", mepc_out, 32'h0000_1234);
        csr("clr mstatus", 2'b01, 12'h300, 32'h0, 32'h0000_1888, 1'b0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        csr("mret mpie set", 2'b10, 12'h300, 32'h0, 32'h0000_1880, 1'b0);

        // Interrupt pending.
        csr("mie timer", 2'b01, 12'h304, 32'h0000_0080, 32'h000F_0880, 1'b0);
        csr("mie enable", 2'b01, 12'h300, 32'h0000_0008, 32'h0000_1880, 1'b0);
        #1;
        chk32("irqPending idle", {31'h0, irq_pend}, 32'h0);
        timer = 1'b1;
        #1;
        chk32("irqPending timer", {31'h0, irq_pend}, 32'h1);
        csr("mip timer", 2'b10, 12'h344, 32'h0, 32'h0000_0080, 1'b0);
        irq = 4'b0010;
        csr("mip lines", 2'b10, 12'h344, 32'h0, 32'h0002_0880, 1'b0);
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_2000;
        trap_cause = 32'h8000_000B;
        csr("trap vs mstatus", 2'b10, 12'h300, 32'h0000_0008, 32'h0000_1808, 1'b0);
        trap_valid = 1'b0;
        chk32("irqPending masked", {31'h0, irq_pend}, 32'h0);
        csr("trap wins MIE", 2'b10, 12'h300, 32'h0, 32'h0000_1880, 1'b0);

        // Same-cycle priority.
        mret = 1'b1;
        csr("mret vs write", 2'b01, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
        mret = 1'b0;
        csr("mret wins", 2'b10, 12'h300, 32'h0, 32'h0000_1888, 1'b0);
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_3000;
        csr("trap + mscratch", 2'b01, 12'h340, 32'h0000_0055, 32'hDEAD_0000, 1'b0);
        trap_valid = 1'b0;
        csr("mscratch proceeds", 2'b10, 12'h340, 32'h0, 32'h0000_0055, 1'b0);
        chk32("mepc from trap", mepc_out, 32'h0000_3000);
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_4002;
        csr("trap + mepc", 2'b01, 12'h341, 32'h0000_8888, 32'h0000_3000, 1'b0);
        trap_valid = 1'b0;
        chk32("mepc trap wins", mepc_out, 32'h0000_4000);
        csr("mtvec direct", 2'b01, 12'h305, 32'h0000_0100, 32'h8000_0101, 1'b0);
        trap_cause = 32'h8000_0007;
        #1;
        chk32("trapTarget direct", tgt, 32'h0000_0100);

`ifdef CSR_COUNTERS_EN
        wr_nochk(12'hB00, 32'hFFFF_FFFF);
        wr_nochk(12'hB80, 32'hFFFF_FFFF);
        csr("mcycleh max", 2'b10, 12'hB80, 32'h0, 32'hFFFF_FFFF, 1'b0);
        csr("mcycle wrap", 2'b10, 12'hB00, 32'h0, 32'h0000_0000, 1'b0);
        csr("mcycleh wrap", 2'b10, 12'hB80, 32'h0, 32'h0000_0000, 1'b0);
        csr("cycle wr ill", 2'b01, 12'hC00, 32'h0000_0007, 32'h0000_0002, 1'b1);
        csr("cycle rd", 2'b10, 12'hC00, 32'h0, 32'h0000_0003, 1'b0);
        retire = 1'b1;
        wr_nochk(12'hB02, 32'h0000_000A);
        wr_nochk(12'hB82, 32'h0000_0000);
        step();
        retire = 1'b0;
        csr("instret", 2'b10, 12'hC02, 32'h0, 32'h0000_000B, 1'b0);
        csr("minstreth", 2'b10, 12'hB82, 32'h0, 32'h0000_0000, 1'b0);
`else
        csr("mcycle absent", 2'b01, 12'hB00, 32'h0000_0005, 32'h0, 1'b1);
        csr("cycle absent", 2'b10, 12'hC00, 32'h0, 32'h0, 1'b1);
        csr("minstreth absent", 2'b01, 12'hB82, 32'h0, 32'h0, 1'b1);
`endif

        // Reset overrides trap, MRET and writes in the same cycle.
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_5000;
        mret       = 1'b1;
        rst_n      = 1'b0;
        csr("reset vs write", 2'b01, 12'h340, 32'h0000_1234, 32'h0000_0055, 1'b0);
        trap_valid = 1'b0;
        mret       = 1'b0;
        chk32("reset mepc", mepc_out, 32'h0);
        chk32("reset irq", {31'h0, irq_pend}, 32'h0);
        csr("reset mstatus2", 2'b10, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        csr("reset mscratch", 2'b10, 12'h340, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        csr("reset mtvec", 2'b10, 12'h305, 32'h0, 32'h0, 1'b0);
        csr("reset mie", 2'b10, 12'h304, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
